rgb_delay_ctrl: RTL and testbench
=================================

RGB_DELAY_CTRL -- requirements
Module: rgb_delay_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable-level cycles required to accept a button edge.
REQ-002 Parameter SETTLE_CYCLES, default 8: idle cycles after each tap load before the next load.
REQ-003 Parameter TAP_W, default 5: tap counter width.
REQ-004 clk  in  1  fast fabric clock; the only clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 btn_raw  in  9  asynchronous buttons; bit map: [0..2] r/g/b_whole, [3..5] r/g/b_rising, [6..8] r/g/b_falling.
REQ-007 ch_enable  in  3  r/g/b channel enables, level.
REQ-008 tap_value  out  9*TAP_W  current tap per button slot, same bit map as btn_raw.
REQ-009 delay_ld  out  9  one-cycle load strobe per slot, to the downstream delay primitive.
REQ-010 cntvalue_out  out  TAP_W  tap value presented with delay_ld.
REQ-011 busy  out  1  high in LOAD or SETTLE.
REQ-012 led_status  out  4  index of the last serviced slot; 4'hF = none.

Function
REQ-013 Each btn_raw bit SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-014 The debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive equal samples; rising accepted level -> one-cycle press pulse.
REQ-015 A press pulse SHALL set pending[i] only if ch_enable of slot i's channel is 1; otherwise it is dropped.
REQ-016 A press with pending[i] already set SHALL be coalesced, so each slot advances one step per service.
REQ-017 Deasserting a channel enable SHALL clear that channel's pending bits in the next cycle; its taps are kept.
REQ-018 FSM states: IDLE, LOAD, SETTLE.
REQ-019 In IDLE, if pending != 0, the FSM SHALL select the lowest-index set bit k and go to LOAD.
REQ-020 On entering LOAD, the FSM SHALL update tap[k] = tap[k]+1 modulo 2^TAP_W (31 wraps to 0 at TAP_W=5) and clear pending[k].
REQ-021 In LOAD, for exactly one cycle, the block SHALL assert delay_ld[k], drive cntvalue_out = new tap[k], and set led_status = k.
REQ-022 The FSM SHALL go from LOAD to SETTLE and hold SETTLE exactly SETTLE_CYCLES cycles, then return to IDLE.
REQ-023 Latency: press pulse in cycle n with FSM in IDLE -> delay_ld in cycle n+2.
REQ-024 New presses arriving in LOAD or SETTLE SHALL still set pending bits.
REQ-025 When delay_ld is 0, cntvalue_out SHALL hold its last driven value.
REQ-026 tap_value SHALL always reflect the registered taps.

Reset
REQ-027 While rst=1, all taps SHALL be 0, pending 0, FSM IDLE, delay_ld 0, cntvalue_out 0, busy 0, led_status 4'hF, synchronizers and debouncers cleared to the released level.
REQ-028 Reset asserted in LOAD or SETTLE SHALL abort with no further strobe; the first strobe after release requires a fresh debounced press.

Structure
REQ-029 A shared package SHALL hold the slot index constants (R_WHOLE=0 .. B_FALLING=8), the FSM state encoding, and LED_NONE=4'hF.
REQ-030 Sub-module button_debounce (synchronizer + counter + press pulse) SHALL be instantiated 9 times.
REQ-031 The scheduler/FSM and tap registers SHALL live in rgb_delay_ctrl.

Verification (bench: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3)
REQ-032 Single press: btn_raw[0] high for 10 cycles -> one delay_ld[0], cntvalue_out=1, tap_value slot0=1, led_status=0.
REQ-033 Glitch: btn_raw[3] high for 2 cycles -> no pending, no delay_ld.
REQ-034 Simultaneous press: bits 2 and 7 pressed together -> delay_ld[2] first, delay_ld[7] exactly 1+3+1 cycles later, each with cntvalue_out=1.
REQ-035 Wrap: 32 debounced presses on slot 5 -> tap 31, then 0, with delay_ld each time.
REQ-036 Disabled channel: ch_enable=3'b110, press slot 0 -> no strobe; enable and press -> tap=1.
REQ-037 Reset mid-SETTLE with slot 1 pending -> outputs at reset values, no delay_ld after release.

Source files
------------

// File: rtl/rgb_delay_ctrl_pkg.sv
// Shared definitions for the RGB delay-tap controller: button slot indices,
// scheduler state encoding, the "no slot serviced" LED code and small helpers.
package rgb_delay_ctrl_pkg;

   localparam int NUM_SLOTS = 9;
   localparam int NUM_CH    = 3;

   // Button slot map: whole / rising / falling groups, each ordered r, g, b
   localparam logic [3:0] R_WHOLE   = 4'd0;
   localparam logic [3:0] G_WHOLE   = 4'd1;
   localparam logic [3:0] B_WHOLE   = 4'd2;
   localparam logic [3:0] R_RISING  = 4'd3;
   localparam logic [3:0] G_RISING  = 4'd4;
   localparam logic [3:0] B_RISING  = 4'd5;
   localparam logic [3:0] R_FALLING = 4'd6;
   localparam logic [3:0] G_FALLING = 4'd7;
   localparam logic [3:0] B_FALLING = 4'd8;

   localparam logic [3:0] LED_NONE  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   // Index of the lowest set bit; LED_NONE when the vector is empty
   function automatic logic [3:0] lowest_set(input logic [NUM_SLOTS-1:0] vec);
      logic [3:0] idx;
      idx = LED_NONE;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         idx = vec[i] ? 4'(i) : idx;
      end
      return idx;
   endfunction

   // Expand the r/g/b enables onto the nine slots (slot i belongs to channel i mod 3)
   function automatic logic [NUM_SLOTS-1:0] slot_enable_mask(input logic [NUM_CH-1:0] en);
      logic [NUM_SLOTS-1:0] mask;
      mask = {NUM_SLOTS{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
         mask[i] = en[i % NUM_CH];
      end
      return mask;
   endfunction

endpackage

// File: rtl/rgb_delay_ctrl_button_debounce.sv
// One button input: 2-flop synchronizer, stable-level debouncer and a
// single-cycle press pulse on each accepted rising level.
module button_debounce
   import rgb_delay_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          press_r;

   // Synchronize the raw input, count consecutive samples that differ from the
   // accepted level and accept the new level once the run is long enough
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else begin
         sync1_r <= btn_raw;
         sync2_r <= sync1_r;
         if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               cnt_r   <= '0;
               press_r <= sync2_r;
            end else begin
               cnt_r   <= cnt_r + CW'(1);
               press_r <= 1'b0;
            end
         end else begin
            cnt_r   <= '0;
            press_r <= 1'b0;
         end
      end
   end

   assign press = press_r;

endmodule

// File: rtl/rgb_delay_ctrl.sv
// RGB delay-tap controller: nine debounced buttons request a one-step tap
// increment; a small scheduler services pending slots lowest-index first,
// strobes the new tap value into the delay primitive and waits a settle time.
module rgb_delay_ctrl
   import rgb_delay_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SETTLE_CYCLES   = 8,
   parameter int TAP_W           = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SLOTS-1:0]       btn_raw,
   input  logic [NUM_CH-1:0]          ch_enable,
   output logic [NUM_SLOTS*TAP_W-1:0] tap_value,
   output logic [NUM_SLOTS-1:0]       delay_ld,
   output logic [TAP_W-1:0]           cntvalue_out,
   output logic                       busy,
   output logic [3:0]                 led_status
);

   localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   logic [NUM_SLOTS-1:0] press_s;
   logic [NUM_SLOTS-1:0] en_mask_s;
   logic [NUM_SLOTS-1:0] clr_s;
   logic [NUM_SLOTS-1:0] pending_nxt_s;
   logic [3:0]           sel_s;
   logic [TAP_W-1:0]     tap_inc_s;
   logic                 load_s;
   state_t               state_nxt_s;

   state_t               state_r;
   logic [NUM_SLOTS-1:0] pending_r;
   logic [SW-1:0]        settle_cnt_r;
   logic [TAP_W-1:0]     tap_r [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] delay_ld_r;
   logic [TAP_W-1:0]     cntvalue_r;
   logic                 busy_r;
   logic [3:0]           led_r;

   genvar g;
   generate
      for (g = 0; g < NUM_SLOTS; g++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[g]),
            .press  (press_s[g])
         );
         assign tap_value[g*TAP_W +: TAP_W] = tap_r[g];
      end
   endgenerate

   // Scheduler next state, slot selection and pending-vector update
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      sel_s       = lowest_set(pending_r);
      en_mask_s   = slot_enable_mask(ch_enable);
      tap_inc_s   = '0;
      case (state_r)
         ST_IDLE: begin
            if (pending_r != {NUM_SLOTS{1'b0}}) begin
               state_nxt_s = ST_LOAD;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_nxt_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      for (int i = 0; i < NUM_SLOTS; i++) begin
         tap_inc_s = (sel_s == 4'(i)) ? tap_r[i] + TAP_W'(1) : tap_inc_s;
      end
      if (load_s) begin
         clr_s = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << sel_s;
      end else begin
         clr_s = {NUM_SLOTS{1'b0}};
      end
      // A press landing in the same cycle as service re-arms the slot;
      // disabled channels drop both old and new requests
      pending_nxt_s = ((pending_r & ~clr_s) | press_s) & en_mask_s;
   end

   // State, pending, settle timer, tap registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         pending_r    <= {NUM_SLOTS{1'b0}};
         settle_cnt_r <= '0;
         delay_ld_r   <= {NUM_SLOTS{1'b0}};
         cntvalue_r   <= '0;
         busy_r       <= 1'b0;
         led_r        <= LED_NONE;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            tap_r[i] <= '0;
         end
      end else begin
         state_r    <= state_nxt_s;
         pending_r  <= pending_nxt_s;
         busy_r     <= (state_nxt_s != ST_IDLE);
         delay_ld_r <= clr_s;
         if (state_r == ST_SETTLE) begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
         end else begin
            settle_cnt_r <= '0;
         end
         if (load_s) begin
            cntvalue_r <= tap_inc_s;
            led_r      <= sel_s;
         end else begin
            cntvalue_r <= cntvalue_r;
            led_r      <= led_r;
         end
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clr_s[i]) begin
               tap_r[i] <= tap_inc_s;
            end else begin
               tap_r[i] <= tap_r[i];
            end
         end
      end
   end

   assign delay_ld     = delay_ld_r;
   assign cntvalue_out = cntvalue_r;
   assign busy         = busy_r;
   assign led_status   = led_r;

endmodule

// File: tb/tb_rgb_delay_ctrl.sv
// Directed self-checking bench for rgb_delay_ctrl with short debounce/settle.
`timescale 1ns/1ps
module tb_rgb_delay_ctrl;

   localparam int TAP_W = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [8:0]   btn_raw = 9'h000;
   logic [2:0]   ch_enable = 3'b111;
   logic [44:0]  tap_value;
   logic [8:0]   delay_ld;
   logic [4:0]   cntvalue_out;
   logic         busy;
   logic [3:0]   led_status;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int strobe_cnt [9];
   int strobe_cyc [9];
   logic [4:0] strobe_val [9];
   logic [3:0] strobe_led [9];

   rgb_delay_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .SETTLE_CYCLES  (3),
      .TAP_W          (TAP_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .ch_enable   (ch_enable),
      .tap_value   (tap_value),
      .delay_ld    (delay_ld),
      .cntvalue_out(cntvalue_out),
      .busy        (busy),
      .led_status  (led_status)
   );

   always #5 clk = ~clk;

   // Record every load strobe seen away from the active edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            if (delay_ld[i]) begin
               strobe_cnt[i] = strobe_cnt[i] + 1;
               strobe_cyc[i] = cyc;
               strobe_val[i] = cntvalue_out;
               strobe_led[i] = led_status;
            end
         end
      end
   end

   function automatic logic [4:0] tap_of(input int s);
      return tap_value[s*TAP_W +: TAP_W];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_raw = 9'h000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_slots(input logic [8:0] m, input int hi, input int lo);
      @(negedge clk);
      btn_raw = m;
      repeat (hi) @(negedge clk);
      btn_raw = 9'h000;
      repeat (lo) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_raw = 9'h000;
      ch_enable = 3'b111;
      repeat (3) @(negedge clk);
      checks++; if (tap_value !== 45'd0) begin errors++; $display("FAIL reset_tap: got %h expected 0", tap_value); end
      checks++; if (delay_ld !== 9'h000) begin errors++; $display("FAIL reset_ld: got %h expected 000", delay_ld); end
      checks++; if (cntvalue_out !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cntvalue_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (led_status !== 4'hF) begin errors++; $display("FAIL reset_led: got %h expected F", led_status); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int b;
      do_reset();
      b = strobe_cnt[0];
      press_slots(9'h001, 10, 20);
      checks++; if (strobe_cnt[0] !== b + 1) begin errors++; $display("FAIL single_strobes: got %0d expected %0d", strobe_cnt[0], b + 1); end
      checks++; if (strobe_val[0] !== 5'd1) begin errors++; $display("FAIL single_cntvalue: got %0d expected 1", strobe_val[0]); end
      checks++; if (strobe_led[0] !== 4'h0) begin errors++; $display("FAIL single_led_at_ld: got %h expected 0", strobe_led[0]); end
      checks++; if (tap_of(0) !== 5'd1) begin errors++; $display("FAIL single_tap: got %0d expected 1", tap_of(0)); end
      checks++; if (cntvalue_out !== 5'd1) begin errors++; $display("FAIL single_cnt_hold: got %0d expected 1", cntvalue_out); end
      checks++; if (led_status !== 4'h0) begin errors++; $display("FAIL single_led: got %h expected 0", led_status); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_glitch();
      int b;
      b = strobe_cnt[3];
      press_slots(9'h008, 2, 25);
      checks++; if (strobe_cnt[3] !== b) begin errors++; $display("FAIL glitch_strobes: got %0d expected %0d", strobe_cnt[3], b); end
      checks++; if (tap_of(3) !== 5'd0) begin errors++; $display("FAIL glitch_tap: got %0d expected 0", tap_of(3)); end
   endtask

   task automatic test_simultaneous();
      int b2;
      int b7;
      do_reset();
      b2 = strobe_cnt[2];
      b7 = strobe_cnt[7];
      press_slots(9'h084, 10, 30);
      checks++; if (strobe_cnt[2] !== b2 + 1) begin errors++; $display("FAIL simul_strobes2: got %0d expected %0d", strobe_cnt[2], b2 + 1); end
      checks++; if (strobe_cnt[7] !== b7 + 1) begin errors++; $display("FAIL simul_strobes7: got %0d expected %0d", strobe_cnt[7], b7 + 1); end
      checks++; if (strobe_cyc[7] - strobe_cyc[2] !== 5) begin errors++; $display("FAIL simul_gap: got %0d expected 5", strobe_cyc[7] - strobe_cyc[2]); end
      checks++; if (strobe_val[2] !== 5'd1) begin errors++; $display("FAIL simul_val2: got %0d expected 1", strobe_val[2]); end
      checks++; if (strobe_val[7] !== 5'd1) begin errors++; $display("FAIL simul_val7: got %0d expected 1", strobe_val[7]); end
      checks++; if (led_status !== 4'h7) begin errors++; $display("FAIL simul_led: got %h expected 7", led_status); end
   endtask

   task automatic test_wrap();
      int b;
      logic [4:0] exp_val;
      do_reset();
      b = strobe_cnt[5];
      for (int n = 1; n <= 32; n++) begin
         exp_val = 5'(n % 32);
         press_slots(9'h020, 10, 12);
         checks++; if (strobe_cnt[5] !== b + n) begin errors++; $display("FAIL wrap_strobes n=%0d: got %0d expected %0d", n, strobe_cnt[5], b + n); end
         checks++; if (strobe_val[5] !== exp_val) begin errors++; $display("FAIL wrap_val n=%0d: got %0d expected %0d", n, strobe_val[5], exp_val); end
      end
      checks++; if (tap_of(5) !== 5'd0) begin errors++; $display("FAIL wrap_tap_final: got %0d expected 0", tap_of(5)); end
   endtask

   task automatic test_disabled();
      int b;
      do_reset();
      ch_enable = 3'b110;
      b = strobe_cnt[0];
      press_slots(9'h001, 10, 20);
      checks++; if (strobe_cnt[0] !== b) begin errors++; $display("FAIL disabled_strobes: got %0d expected %0d", strobe_cnt[0], b); end
      checks++; if (tap_of(0) !== 5'd0) begin errors++; $display("FAIL disabled_tap: got %0d expected 0", tap_of(0)); end
      checks++; if (led_status !== 4'hF) begin errors++; $display("FAIL disabled_led: got %h expected F", led_status); end
      ch_enable = 3'b111;
      press_slots(9'h001, 10, 20);
      checks++; if (strobe_cnt[0] !== b + 1) begin errors++; $display("FAIL enabled_strobes: got %0d expected %0d", strobe_cnt[0], b + 1); end
      checks++; if (tap_of(0) !== 5'd1) begin errors++; $display("FAIL enabled_tap: got %0d expected 1", tap_of(0)); end
   endtask

   task automatic test_reset_mid_settle();
      bit ok;
      int b0;
      int b1;
      do_reset();
      ok = 1'b0;
      @(negedge clk);
      btn_raw = 9'h003;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         ok = delay_ld[0];
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midreset_first_ld: got %b expected 1", ok); end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b expected 1", busy); end
      btn_raw = 9'h000;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tap_value !== 45'd0) begin errors++; $display("FAIL midreset_tap: got %h expected 0", tap_value); end
      checks++; if (delay_ld !== 9'h000) begin errors++; $display("FAIL midreset_ld: got %h expected 000", delay_ld); end
      checks++; if (cntvalue_out !== 5'd0) begin errors++; $display("FAIL midreset_cnt: got %0d expected 0", cntvalue_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_rst: got %b expected 0", busy); end
      checks++; if (led_status !== 4'hF) begin errors++; $display("FAIL midreset_led: got %h expected F", led_status); end
      rst = 1'b0;
      b0 = strobe_cnt[0];
      b1 = strobe_cnt[1];
      repeat (30) @(negedge clk);
      checks++; if (strobe_cnt[1] !== b1) begin errors++; $display("FAIL midreset_no_ld1: got %0d expected %0d", strobe_cnt[1], b1); end
      checks++; if (strobe_cnt[0] !== b0) begin errors++; $display("FAIL midreset_no_ld0: got %0d expected %0d", strobe_cnt[0], b0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got %b expected 0", busy); end
   endtask

   initial begin
      for (int i = 0; i < 9; i++) begin
         strobe_cnt[i] = 0;
         strobe_cyc[i] = 0;
         strobe_val[i] = 5'd0;
         strobe_led[i] = 4'h0;
      end
      test_reset();
      test_single();
      test_glitch();
      test_simultaneous();
      test_wrap();
      test_disabled();
      test_reset_mid_settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
